// File: rtl/random_stim_checker.sv
// Random stimulus generator and output comparator for fabric-vs-reference equivalence runs.
// A Galois LFSR drives both sides; masked bitwise mismatches are counted and the first is captured.
module random_stim_checker #(
    parameter int unsigned NUM_IN      = 2,
    parameter int unsigned NUM_OUT     = 1,
    parameter logic [31:0] LFSR_SEED   = 32'hACE12345,
    parameter int unsigned SKIP_CYCLES = 1,
    parameter int unsigned RUN_CYCLES  = 400,
    parameter int unsigned COUNT_MODE  = 1,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [NUM_IN-1:0]    stim_out,
    input  logic [NUM_OUT-1:0]   dut_out,
    input  logic [NUM_OUT-1:0]   ref_out,
    input  logic [NUM_OUT-1:0]   cmp_mask,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_OUT-1:0]   mismatch_flag,
    output logic                 mismatch_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [31:0]          first_err_cycle,
    output logic [NUM_OUT-1:0]   first_err_vec
);

    typedef enum logic [1:0] {StIdle, StSkip, StRun, StDone} state_e;

    localparam logic [31:0]          Taps     = 32'h80200003;
    localparam logic [31:0]          SeedEff  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [ERR_CNT_W-1:0] ErrMax   = '1;
    localparam logic [31:0]          LastIdx  = 32'(RUN_CYCLES - 1);
    localparam logic [7:0]           SkipLast = 8'(SKIP_CYCLES - 1);
    localparam state_e               StFirst  = (SKIP_CYCLES == 0) ? StRun : StSkip;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? Taps : 32'd0);
    endfunction

    state_e               state_q, state_d;
    logic [31:0]          lfsr_q, lfsr_d;
    logic [NUM_IN-1:0]    stim_q, stim_d;
    logic [7:0]           skip_cnt_q, skip_cnt_d;
    logic [31:0]          idx_q, idx_d;
    logic                 prev_any_q, prev_any_d;
    logic                 captured_q, captured_d;
    logic [NUM_OUT-1:0]   flag_q, flag_d;
    logic                 pulse_q, pulse_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [31:0]          fcyc_q, fcyc_d;
    logic [NUM_OUT-1:0]   fvec_q, fvec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic [31:0]          lfsr_adv;
    logic [NUM_OUT-1:0]   cmp_vec;
    logic                 cmp_any;
    logic                 cmp_rise;
    logic                 err_inc;

    always_comb begin
        lfsr_adv = lfsr_next(lfsr_q);
        cmp_vec  = (dut_out ^ ref_out) & cmp_mask;
        cmp_any  = |cmp_vec;
        cmp_rise = cmp_any & ~prev_any_q;
        err_inc  = (COUNT_MODE == 0) ? cmp_any : cmp_rise;

        state_d    = state_q;
        lfsr_d     = lfsr_q;
        stim_d     = stim_q;
        skip_cnt_d = skip_cnt_q;
        idx_d      = idx_q;
        prev_any_d = prev_any_q;
        captured_d = captured_q;
        flag_d     = flag_q;
        pulse_d    = pulse_q;
        err_d      = err_q;
        fcyc_d     = fcyc_q;
        fvec_d     = fvec_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StFirst;
                    lfsr_d     = SeedEff;
                    stim_d     = SeedEff[NUM_IN-1:0];
                    skip_cnt_d = 8'd0;
                    idx_d      = 32'd0;
                    prev_any_d = 1'b0;
                    captured_d = 1'b0;
                    flag_d     = '0;
                    pulse_d    = 1'b0;
                    err_d      = '0;
                    fcyc_d     = '1;
                    fvec_d     = '0;
                end
            end
            StSkip: begin
                lfsr_d     = lfsr_adv;
                stim_d     = lfsr_adv[NUM_IN-1:0];
                skip_cnt_d = skip_cnt_q + 8'd1;
                if (skip_cnt_q == SkipLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                lfsr_d     = lfsr_adv;
                stim_d     = lfsr_adv[NUM_IN-1:0];
                flag_d     = cmp_vec;
                pulse_d    = cmp_rise;
                prev_any_d = cmp_any;
                idx_d      = idx_q + 32'd1;
                if (err_inc && (err_q != ErrMax)) begin
                    err_d = err_q + ERR_CNT_W'(1);
                end
                if (cmp_any && !captured_q) begin
                    captured_d = 1'b1;
                    fcyc_d     = idx_q;
                    fvec_d     = cmp_vec;
                end
                // The last compare still counts, but its flag/pulse are dropped on DONE entry.
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    flag_d  = '0;
                    pulse_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StSkip) || (state_d == StRun);
        done_d = (state_d == StDone);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lfsr_q     <= SeedEff;
            stim_q     <= '0;
            skip_cnt_q <= 8'd0;
            idx_q      <= 32'd0;
            prev_any_q <= 1'b0;
            captured_q <= 1'b0;
            flag_q     <= '0;
            pulse_q    <= 1'b0;
            err_q      <= '0;
            fcyc_q     <= '1;
            fvec_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            stim_q     <= stim_d;
            skip_cnt_q <= skip_cnt_d;
            idx_q      <= idx_d;
            prev_any_q <= prev_any_d;
            captured_q <= captured_d;
            flag_q     <= flag_d;
            pulse_q    <= pulse_d;
            err_q      <= err_d;
            fcyc_q     <= fcyc_d;
            fvec_q     <= fvec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign stim_out        = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign mismatch_flag   = flag_q;
    assign mismatch_pulse  = pulse_q;
    assign err_count       = err_q;
    assign first_err_cycle = fcyc_q;
    assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_random_stim_checker.sv
// Randomized bench for random_stim_checker: two configurations driven from fault/mask tables,
// final results predicted by a per-run model of the counting and capture rules.
module tb_random_stim_checker;

    localparam int RUN_A  = 400;
    localparam int SKIP_A = 1;
    localparam int RUN_B  = 40;
    localparam int SKIP_B = 0;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic [1:0]  stim_a;
    logic [7:0]  stim_b;
    logic [3:0]  dut_a, ref_a, mask_a, flt_cur_a, flag_a, fvec_a;
    logic [3:0]  dut_b, ref_b, mask_b, flt_cur_b, flag_b, fvec_b;
    logic        busy_a, done_a, pass_a, pulse_a;
    logic        busy_b, done_b, pass_b, pulse_b;
    logic [15:0] err_a;
    logic [3:0]  err_b;
    logic [31:0] fcyc_a, fcyc_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0]  flt [RUN_A];
    logic [3:0]  msk [RUN_A];

    logic [31:0] o_stim, o_err, o_fcyc;
    logic        o_busy, o_done, o_pass, o_pulse;
    logic [3:0]  o_flag, o_fvec;

    assign ref_a = {stim_a[1], stim_a[0], stim_a[0] ^ stim_a[1], stim_a[0] & stim_a[1]};
    assign dut_a = ref_a ^ flt_cur_a;
    assign ref_b = stim_b[3:0] ^ stim_b[7:4];
    assign dut_b = ref_b ^ flt_cur_b;

    random_stim_checker #(
        .NUM_IN(2), .NUM_OUT(4), .LFSR_SEED(32'hACE12345), .SKIP_CYCLES(SKIP_A),
        .RUN_CYCLES(RUN_A), .COUNT_MODE(1), .ERR_CNT_W(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stim_out(stim_a), .dut_out(dut_a),
        .ref_out(ref_a), .cmp_mask(mask_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .mismatch_flag(flag_a), .mismatch_pulse(pulse_a), .err_count(err_a),
        .first_err_cycle(fcyc_a), .first_err_vec(fvec_a)
    );

    random_stim_checker #(
        .NUM_IN(8), .NUM_OUT(4), .LFSR_SEED(32'h0), .SKIP_CYCLES(SKIP_B),
        .RUN_CYCLES(RUN_B), .COUNT_MODE(0), .ERR_CNT_W(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stim_out(stim_b), .dut_out(dut_b),
        .ref_out(ref_b), .cmp_mask(mask_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .mismatch_flag(flag_b), .mismatch_pulse(pulse_b), .err_count(err_b),
        .first_err_cycle(fcyc_b), .first_err_vec(fvec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Polynomial x^32+x^22+x^2+x+1 in right-shifting Galois form.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'd0);
    endfunction

    task automatic set_drive(input int sel, input logic [3:0] f, input logic [3:0] m,
                             input logic st);
        if (sel == 0) begin
            flt_cur_a = f; mask_a = m; start_a = st;
        end else begin
            flt_cur_b = f; mask_b = m; start_b = st;
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            o_stim = {30'd0, stim_a}; o_busy = busy_a; o_done = done_a; o_pass = pass_a;
            o_flag = flag_a; o_pulse = pulse_a; o_err = {16'd0, err_a}; o_fcyc = fcyc_a;
            o_fvec = fvec_a;
        end else begin
            o_stim = {24'd0, stim_b}; o_busy = busy_b; o_done = done_b; o_pass = pass_b;
            o_flag = flag_b; o_pulse = pulse_b; o_err = {28'd0, err_b}; o_fcyc = fcyc_b;
            o_fvec = fvec_b;
        end
    endtask

    task automatic fill(input logic [3:0] f, input logic [3:0] m);
        for (int i = 0; i < RUN_A; i++) begin
            flt[i] = f;
            msk[i] = m;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < RUN_A; i++) begin
            flt[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            msk[i] = 4'($urandom);
        end
    endtask

    task automatic check_reset_state(input int sel, input string tag);
        sample(sel);
        check_eq({tag, ".stim"}, 64'(o_stim), 64'd0);
        check_eq({tag, ".err"}, 64'(o_err), 64'd0);
        check_eq({tag, ".fcyc"}, 64'(o_fcyc), 64'hFFFFFFFF);
        check_eq({tag, ".fvec"}, 64'(o_fvec), 64'd0);
        check_eq({tag, ".flag"}, 64'(o_flag), 64'd0);
        check_eq({tag, ".ctl"}, 64'({o_busy, o_done, o_pass, o_pulse}), 64'd0);
    endtask

    task automatic do_run(input int sel, input int abort_at, input int restart_at,
                          input string tag);
        int          skip, run, mode, w;
        int          any_cnt, rises, vis_rises, first;
        int          bad_stim, bad_busy, bad_flag, pulses;
        longint      exp_err, lim;
        logic [3:0]  fvec_e, f, m;
        logic        prev, a;
        logic [31:0] lf, exp_stim;

        skip = (sel == 0) ? SKIP_A : SKIP_B;
        run  = (sel == 0) ? RUN_A : RUN_B;
        mode = (sel == 0) ? 1 : 0;
        w    = (sel == 0) ? 16 : 4;
        lf   = (sel == 0) ? 32'hACE12345 : 32'd1;

        any_cnt = 0; rises = 0; vis_rises = 0; first = -1; fvec_e = 4'h0; prev = 1'b0;
        for (int i = 0; i < run; i++) begin
            a = |(flt[i] & msk[i]);
            if (a && !prev) begin
                rises++;
                if (i < run - 1) vis_rises++;
            end
            if (a) any_cnt++;
            if (a && first < 0) begin
                first  = i;
                fvec_e = flt[i] & msk[i];
            end
            prev = a;
        end
        exp_err = (mode == 1) ? longint'(rises) : longint'(any_cnt);
        lim     = (longint'(1) << w) - 1;
        if (exp_err > lim) exp_err = lim;

        @(negedge clk);
        set_drive(sel, 4'h0, 4'h0, 1'b1);
        @(posedge clk);
        #1;
        bad_stim = 0; bad_busy = 0; bad_flag = 0; pulses = 0;
        for (int k = 0; k < skip + run; k++) begin
            sample(sel);
            exp_stim = (sel == 0) ? {30'd0, lf[1:0]} : {24'd0, lf[7:0]};
            if (o_stim != exp_stim) bad_stim++;
            if (!o_busy || o_done) bad_busy++;
            if (k >= skip + 1) begin
                if (o_flag != (flt[k-skip-1] & msk[k-skip-1])) bad_flag++;
                if (o_pulse) pulses++;
            end
            if (k >= skip) begin
                f = flt[k-skip];
                m = msk[k-skip];
            end else begin
                f = 4'($urandom);
                m = 4'hF;
            end
            set_drive(sel, f, m, k == restart_at);
            if (abort_at >= 0 && k == skip + abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                set_drive(sel, 4'h0, 4'h0, 1'b0);
                sample(sel);
                check_eq({tag, ".abort_busy"}, 64'(o_busy), 64'd0);
                check_eq({tag, ".abort_err"}, 64'(o_err), 64'd0);
                check_eq({tag, ".abort_stim"}, 64'(o_stim), 64'd0);
                check_eq({tag, ".abort_fcyc"}, 64'(o_fcyc), 64'hFFFFFFFF);
                check_eq({tag, ".abort_stim_seq"}, 64'(bad_stim), 64'd0);
                return;
            end
            lf = lfsr_step(lf);
            @(posedge clk);
            #1;
        end
        set_drive(sel, 4'h0, 4'h0, 1'b0);
        sample(sel);
        exp_stim = (sel == 0) ? {30'd0, lf[1:0]} : {24'd0, lf[7:0]};
        check_eq({tag, ".done"}, 64'(o_done), 64'd1);
        check_eq({tag, ".busy"}, 64'(o_busy), 64'd0);
        check_eq({tag, ".pass"}, 64'(o_pass), 64'(exp_err == 0));
        check_eq({tag, ".err"}, 64'(o_err), 64'(exp_err));
        check_eq({tag, ".fcyc"}, 64'(o_fcyc), (first < 0) ? 64'hFFFFFFFF : 64'(first));
        check_eq({tag, ".fvec"}, 64'(o_fvec), 64'(fvec_e));
        check_eq({tag, ".flag_clr"}, 64'({o_flag, o_pulse}), 64'd0);
        check_eq({tag, ".pulses"}, 64'(pulses), 64'(vis_rises));
        check_eq({tag, ".stim_seq"}, 64'(bad_stim), 64'd0);
        check_eq({tag, ".stim_hold"}, 64'(o_stim), 64'(exp_stim));
        check_eq({tag, ".busy_seq"}, 64'(bad_busy), 64'd0);
        check_eq({tag, ".flag_seq"}, 64'(bad_flag), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        set_drive(0, 4'h0, 4'h0, 1'b0);
        set_drive(1, 4'h0, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0, "rst_a");
        check_reset_state(1, "rst_b");
        @(negedge clk);
        rst = 1'b0;

        fill(4'h0, 4'hF);
        for (int i = 0; i < RUN_A; i++) msk[i] = 4'($urandom);
        do_run(0, -1, -1, "a_match");

        fill(4'h0, 4'hF);
        flt[10] = 4'b0001;
        do_run(0, -1, -1, "a_single");

        fill(4'h0, 4'hF);
        flt[5] = 4'b0001; flt[6] = 4'b0001; flt[7] = 4'b0001;
        do_run(0, -1, -1, "a_mode1");

        fill(4'hF, 4'h0);
        do_run(0, -1, -1, "a_mask0");

        fill(4'h0, 4'b0100);
        flt[0] = 4'hF;
        do_run(0, -1, -1, "a_mask4");

        for (int r = 0; r < 2; r++) begin
            fill_random();
            do_run(0, -1, -1, $sformatf("a_rand%0d", r));
        end

        fill_random();
        flt[3] = 4'h1; msk[3] = 4'hF;
        do_run(0, 50, -1, "a_abort");
        fill(4'h0, 4'hF);
        do_run(0, -1, -1, "a_after_abort");

        fill(4'h0, 4'hF);
        flt[5] = 4'b0010; flt[6] = 4'b0010; flt[7] = 4'b0010;
        do_run(1, -1, -1, "b_mode0");

        fill(4'hF, 4'hF);
        do_run(1, -1, 20, "b_sat");

        fill_random();
        do_run(1, -1, -1, "b_rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
